// File: rtl/cdma_frame_ctrl.sv
// CDMA frame controller: round-robin grants one of four users a frame of data
// bits, each bit spread over CHIPS_PER_BIT chips of a per-user-seeded Gold code.
module cdma_frame_ctrl #(
    parameter int CHIPS_PER_BIT  = 31,
    parameter int BITS_PER_FRAME = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic [3:0] data_i,
    input  logic       cfg_we_i,
    input  logic [1:0] cfg_addr_i,
    input  logic [3:0] cfg_seed_i,
    output logic [3:0] grant_o,
    output logic [3:0] ack_o,
    output logic       chip_o,
    output logic       chip_valid_o,
    output logic       gold_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    typedef enum logic [1:0] {IDLE, LOAD, SPREAD, DONE} state_e;

    localparam logic [4:0] LAST_CHIP  = 5'(CHIPS_PER_BIT - 1);
    localparam logic [3:0] FRAME_BITS = 4'(BITS_PER_FRAME);

    state_e     state_q, state_d;
    logic [3:0] seedTab_q [4];
    logic [3:0] activeSeed_q, activeSeed_d;
    logic [4:0] lfsrA_q, lfsrA_d;
    logic [4:0] lfsrB_q, lfsrB_d;
    logic [4:0] chipCnt_q, chipCnt_d;
    logic [3:0] bitCnt_q, bitCnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] winner_q, winner_d;
    logic       dataBit_q, dataBit_d;

    logic [3:0] eligible;
    logic       hit;
    logic [1:0] pick;
    logic [3:0] loadSeed;
    logic       lastChip;
    logic       moreBits;
    logic [3:0] winnerOneHot;

    function automatic logic [4:0] stepA(input logic [4:0] v);
        return {v[3:0], v[4] ^ v[3] ^ v[2] ^ v[1]};
    endfunction

    function automatic logic [4:0] stepB(input logic [4:0] v);
        return {v[3:0], v[4] ^ v[1]};
    endfunction

    function automatic logic [4:0] seedWord(input logic [3:0] s);
        return {s, s[0]};
    endfunction

    // Seed table is registered, so a write in the same cycle as arbitration
    // or LOAD is seen only from the following cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seedTab_q[0] <= 4'd1;
            seedTab_q[1] <= 4'd2;
            seedTab_q[2] <= 4'd3;
            seedTab_q[3] <= 4'd4;
        end else if (cfg_we_i) begin
            seedTab_q[cfg_addr_i] <= cfg_seed_i;
        end
    end

    always_comb begin
        for (int u = 0; u < 4; u++) begin
            eligible[u] = req_i[u] && (seedTab_q[u] != 4'd0);
        end
    end

    always_comb begin
        hit  = 1'b0;
        pick = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!hit && eligible[ptr_q + 2'(k)]) begin
                hit  = 1'b1;
                pick = ptr_q + 2'(k);
            end
        end
    end

    assign loadSeed     = seedTab_q[winner_q];
    assign lastChip     = (chipCnt_q == LAST_CHIP);
    assign moreBits     = ((bitCnt_q + 4'd1) < FRAME_BITS) && req_i[winner_q];
    assign winnerOneHot = 4'b0001 << winner_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            activeSeed_q <= 4'd0;
            lfsrA_q      <= 5'd0;
            lfsrB_q      <= 5'd0;
            chipCnt_q    <= 5'd0;
            bitCnt_q     <= 4'd0;
            ptr_q        <= 2'd0;
            winner_q     <= 2'd0;
            dataBit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            activeSeed_q <= activeSeed_d;
            lfsrA_q      <= lfsrA_d;
            lfsrB_q      <= lfsrB_d;
            chipCnt_q    <= chipCnt_d;
            bitCnt_q     <= bitCnt_d;
            ptr_q        <= ptr_d;
            winner_q     <= winner_d;
            dataBit_q    <= dataBit_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        activeSeed_d = activeSeed_q;
        lfsrA_d      = lfsrA_q;
        lfsrB_d      = lfsrB_q;
        chipCnt_d    = chipCnt_q;
        bitCnt_d     = bitCnt_q;
        ptr_d        = ptr_q;
        winner_d     = winner_q;
        dataBit_d    = dataBit_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    winner_d = pick;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                activeSeed_d = loadSeed;
                lfsrA_d      = seedWord(loadSeed);
                lfsrB_d      = seedWord(loadSeed);
                dataBit_d    = data_i[winner_q];
                chipCnt_d    = 5'd0;
                bitCnt_d     = 4'd0;
                state_d      = SPREAD;
            end
            SPREAD: begin
                // Reloading from the active seed at each bit boundary gives
                // every bit of the frame the same chip sequence.
                if (lastChip) begin
                    chipCnt_d = 5'd0;
                    bitCnt_d  = bitCnt_q + 4'd1;
                    lfsrA_d   = seedWord(activeSeed_q);
                    lfsrB_d   = seedWord(activeSeed_q);
                    if (moreBits) begin
                        dataBit_d = data_i[winner_q];
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    chipCnt_d = chipCnt_q + 5'd1;
                    lfsrA_d   = stepA(lfsrA_q);
                    lfsrB_d   = stepB(lfsrB_q);
                end
            end
            DONE: begin
                ptr_d   = winner_q + 2'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gold_o = lfsrA_q[4] ^ lfsrB_q[4];

    always_comb begin
        grant_o      = 4'd0;
        ack_o        = 4'd0;
        chip_o       = 1'b0;
        chip_valid_o = 1'b0;
        busy_o       = (state_q != IDLE);
        frame_done_o = (state_q == DONE);
        if (state_q == LOAD) begin
            grant_o = winnerOneHot;
        end
        if (state_q == SPREAD) begin
            grant_o      = winnerOneHot;
            chip_valid_o = 1'b1;
            chip_o       = dataBit_q ^ gold_o;
            if (lastChip) begin
                ack_o = winnerOneHot;
            end
        end
    end

endmodule

// File: doc/cdma_frame_ctrl.md
CDMA_FRAME_CTRL -- requirements
Module: cdma_frame_ctrl

Interface
REQ-001 Parameter CHIPS_PER_BIT, default 31, chips spread per data bit (legal 2..31) SHALL be supported.
REQ-002 Parameter BITS_PER_FRAME, default 8, data bits per granted frame (legal 1..15) SHALL be supported.
REQ-003 Ports SHALL be:
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  4  per-user transmit request
- data_i  in  4  per-user current data bit
- cfg_we_i  in  1  seed-table write strobe
- cfg_addr_i  in  2  seed-table index
- cfg_seed_i  in  4  seed value to write
- grant_o  out  4  one-hot grant
- ack_o  out  4  one-cycle pulse: bit of that user consumed
- chip_o  out  1  spread chip (data XOR Gold)
- chip_valid_o  out  1  chip_o valid this cycle
- gold_o  out  1  raw Gold chip
- busy_o  out  1  FSM not in IDLE
- frame_done_o  out  1  one-cycle end-of-frame pulse

Function
REQ-004 The block SHALL contain two 5-bit LFSRs, A and B, each shifting left one bit per SPREAD cycle: A feedback = A[4]^A[3]^A[2]^A[1], B feedback = B[4]^B[1], inserted at bit 0.
REQ-005 Gold chip SHALL be A[4]^B[4]; gold_o SHALL present it combinationally at all times.
REQ-006 An LFSR load SHALL set both A and B to {seed, seed[0]}, with seed taken from the active seed register.
REQ-007 The 4x4 seed table SHALL be written on cfg_we_i at cfg_addr_i in any state; a seed value of 0 marks that user disabled.
REQ-008 The FSM states SHALL be IDLE, LOAD, SPREAD, DONE.
REQ-009 In IDLE, eligible users (req_i high and seed nonzero) SHALL be searched round-robin starting at the pointer; on a hit, the next state is LOAD and the winner is latched.
REQ-010 In LOAD (1 cycle), the block SHALL copy the winner's seed into the active seed register, load the LFSRs, latch the winner's data_i, clear the chip and bit counters, and go to SPREAD.
REQ-011 In SPREAD, each cycle SHALL drive chip_valid_o=1 and chip_o=latched_bit^gold, advance the LFSRs, and increment the chip counter.
REQ-012 On the last chip (counter = CHIPS_PER_BIT-1), the block SHALL pulse ack_o[winner], increment the bit counter, and reload the LFSRs from the active seed, so every bit uses the same chip sequence.
- Continuation: if bits sent < BITS_PER_FRAME and req_i[winner] is still high, the block SHALL latch data_i[winner] and stay in SPREAD with no gap cycle.
- Otherwise it SHALL go to DONE.
REQ-013 In DONE (1 cycle), the block SHALL pulse frame_done_o, set pointer = winner+1 mod 4, and return to IDLE.
REQ-014 grant_o SHALL be one-hot for the winner in LOAD and SPREAD, and 0 otherwise; busy_o SHALL be high in LOAD, SPREAD and DONE.
REQ-015 Latency: a request sampled at edge k SHALL give LOAD during cycle k+1 and the first chip_valid_o in cycle k+2.
REQ-016 Full-length frame duration SHALL be 1 + BITS_PER_FRAME*CHIPS_PER_BIT + 1 busy cycles.
REQ-017 req_i dropping mid-bit SHALL NOT truncate that bit; the frame ends at that bit's boundary.
REQ-018 A seed write to the granted user during a frame SHALL NOT affect the frame in progress; it applies from the next LOAD.
REQ-019 A simultaneous seed write and IDLE arbitration SHALL use the old seed for eligibility that cycle.
REQ-020 The chip counter SHALL be 5 bits and never exceed CHIPS_PER_BIT-1; the bit counter SHALL be 4 bits.
REQ-021 Outside SPREAD, chip_valid_o, chip_o and ack_o SHALL be 0.

Reset
REQ-022 rst_i high SHALL immediately force: FSM to IDLE, pointer to 0, counters to 0, A=B=5'b00000, active seed 0, all outputs 0.
REQ-023 Reset SHALL set the seed table to user0=1, user1=2, user2=3, user3=4.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no ack_o or frame_done_o pulse; operation resumes from IDLE after release.

Verification
REQ-025 Scenario: user0 seed 1, data_i[0]=1, req held -> chips 0..6 of every bit = 1,1,1,1,1,1,0; with data 0 they are 0,0,0,0,0,0,1.
REQ-026 Scenario: req_i=4'b1111 held, all seeds nonzero -> grants in order 0,1,2,3,0, each frame 250 busy cycles at defaults, 8 ack_o pulses per frame.
REQ-027 Scenario: write seed 0 to user1, req_i=4'b0010 -> busy_o stays 0, no grant.
REQ-028 Scenario: req_i[2] dropped during chip 10 of bit 3 -> bit 3 completes (31 chips), 4 acks total, DONE follows, frame_done_o pulses once.
REQ-029 Scenario: rst_i pulsed during SPREAD -> same-cycle outputs 0, seed table back to 1,2,3,4, next grant goes to user0.
REQ-030 Scenario: seed write to the active user mid-frame -> the remaining bits of that frame keep the old chip sequence; the next frame uses the new seed.
